// File: rtl/counter_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_cmd_pkg                                                    |
// | Command word layout, sequencer FSM encoding and count constants.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package counter_cmd_pkg;

  localparam int MODO_W = 2;
  localparam int D_W    = 4;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 5;
  localparam int CMD_W  = 1 + LEN_W + D_W + MODO_W;

  // Word layout: {until_rco, len, d, modo}
  localparam int MODO_LSB  = 0;
  localparam int D_LSB     = MODO_LSB + MODO_W;
  localparam int LEN_LSB   = D_LSB + D_W;
  localparam int UNTIL_BIT = LEN_LSB + LEN_W;

  localparam logic [CNT_W-1:0] LEN_ZERO_CNT = 5'd16;
  localparam logic [CNT_W-1:0] CNT_ONE      = 5'd1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  function automatic logic [CNT_W-1:0] len_to_cnt(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_ZERO_CNT : {1'b0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_fifo                                                           |
// | Synchronous FIFO with wrap-bit pointers and a flush that wins.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/counter_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_cmd_sequencer                                              |
// | Queues counter commands and replays them on enable/modo/D.         |
// | Optional: CMD_SEQ_TIMEOUT_EN adds an until-rco timeout and err.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter_cmd_sequencer
  import counter_cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MODO_W-1:0] cmd_modo,
  input  logic [D_W-1:0]    cmd_d,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_until_rco,
  input  logic              abort,
  input  logic              rco,
  input  logic [D_W-1:0]    Q,
  output logic              enable,
  output logic [MODO_W-1:0] modo,
  output logic [D_W-1:0]    D,
  output logic              busy,
  output logic              done,
`ifdef CMD_SEQ_TIMEOUT_EN
  output logic              err,
`endif
  output logic [D_W-1:0]    q_last
);

  seq_state_e        state_q, state_d;
  logic [MODO_W-1:0] modo_q, modo_d;
  logic [D_W-1:0]    cmd_d_q, cmd_d_d;
  logic              until_q, until_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [D_W-1:0]    q_last_q, q_last_d;
  logic              done_q, done_d;
  logic              run_exit;

  logic [CMD_W-1:0]  fifo_din, fifo_dout;
  logic              fifo_pop, fifo_full, fifo_empty;

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_ONE = 1;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));
  assign err     = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  assign fifo_din = {cmd_until_rco, cmd_len, cmd_d, cmd_modo};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    modo_d   = modo_q;
    cmd_d_d  = cmd_d_q;
    until_d  = until_q;
    cnt_d    = cnt_q;
    q_last_d = q_last_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    run_exit = 1'b0;
`ifdef CMD_SEQ_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            modo_d   = fifo_dout[MODO_LSB +: MODO_W];
            cmd_d_d  = fifo_dout[D_LSB +: D_W];
            until_d  = fifo_dout[UNTIL_BIT];
            cnt_d    = len_to_cnt(fifo_dout[LEN_LSB +: LEN_W]);
            state_d  = ST_RUN;
`ifdef CMD_SEQ_TIMEOUT_EN
            tmo_d    = TMO_ONE;
`endif
          end
        end
        ST_RUN: begin
          if (until_q) begin
`ifdef CMD_SEQ_TIMEOUT_EN
            // A timeout that coincides with rco is a normal completion.
            if (rco || tmo_hit) begin
              run_exit = 1'b1;
              if (!rco) err_d = 1'b1;
            end else begin
              tmo_d = tmo_q + TMO_ONE;
            end
`else
            run_exit = rco;
`endif
          end else if (cnt_q == CNT_ONE) begin
            run_exit = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
          if (run_exit) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            q_last_d = Q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      modo_q   <= '0;
      cmd_d_q  <= '0;
      until_q  <= 1'b0;
      cnt_q    <= '0;
      q_last_q <= '0;
      done_q   <= 1'b0;
`ifdef CMD_SEQ_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      modo_q   <= modo_d;
      cmd_d_q  <= cmd_d_d;
      until_q  <= until_d;
      cnt_q    <= cnt_d;
      q_last_q <= q_last_d;
      done_q   <= done_d;
`ifdef CMD_SEQ_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign enable    = (state_q == ST_RUN);
  assign modo      = modo_q;
  assign D         = cmd_d_q;
  assign done      = done_q;
  assign q_last    = q_last_q;
  assign busy      = enable || !fifo_empty;
  assign cmd_ready = !fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_counter_cmd_sequencer                                           |
// | Directed bench for the counter command sequencer.                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_counter_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_until_rco, abort, rco;
  logic [1:0] cmd_modo;
  logic [3:0] cmd_d, cmd_len, q_in;
  logic       cmd_ready, enable, busy, done;
  logic [1:0] modo;
  logic [3:0] D, q_last;
`ifdef CMD_SEQ_TIMEOUT_EN
  logic       err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic       en_prev = 1'b0;
  logic [3:0] starts[$];
  int         n_done = 0;

  always #5 clk = ~clk;

  counter_cmd_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_modo      (cmd_modo),
    .cmd_d         (cmd_d),
    .cmd_len       (cmd_len),
    .cmd_until_rco (cmd_until_rco),
    .abort         (abort),
    .rco           (rco),
    .Q             (q_in),
    .enable        (enable),
    .modo          (modo),
    .D             (D),
    .busy          (busy),
    .done          (done),
`ifdef CMD_SEQ_TIMEOUT_EN
    .err           (err),
`endif
    .q_last        (q_last)
  );

  // Records D at each command start and counts done pulses.
  always @(negedge clk) begin
    if (enable && !en_prev) starts.push_back(D);
    if (done) n_done++;
    en_prev = enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    q_in = q_in + 4'd3;
  endtask

  task automatic push(input logic [1:0] m, input logic [3:0] d, input logic [3:0] l,
                      input logic u, output int waited);
    logic ok;
    cmd_modo = m; cmd_d = d; cmd_len = l; cmd_until_rco = u;
    cmd_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 40) begin
      ok = cmd_ready;
      tick();
      waited++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL push_accept got no accept want accept within 40 cycles");
    end
  endtask

  task automatic test_reset();
    int w;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL rst_enable got %b want 0", enable); end
    n_vec++; if (modo !== 2'd0) begin n_bad++; $display("FAIL rst_modo got %h want 0", modo); end
    n_vec++; if (D !== 4'd0) begin n_bad++; $display("FAIL rst_D got %h want 0", D); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (q_last !== 4'd0) begin n_bad++; $display("FAIL rst_q_last got %h want 0", q_last); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    // Reset held across an active command with one more queued.
    push(2'd1, 4'h7, 4'd0, 1'b0, w);
    tick();
    push(2'd2, 4'h3, 4'd2, 1'b0, w);
    tick();
    n_vec++; if (enable !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_enable got %b want 1", enable); end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL midrst_enable got %b want 0", enable); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", done); end
    n_vec++; if (q_last !== 4'd0) begin n_bad++; $display("FAIL midrst_q_last got %h want 0", q_last); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    repeat (3) tick();
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL midrst_lost got %b want 0", enable); end
  endtask

  task automatic test_length();
    int w;
    logic [3:0] exp_q;
    push(2'd0, 4'h5, 4'd3, 1'b0, w);
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL len_c0_enable got %b want 0", enable); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL len_c0_busy got %b want 1", busy); end
    tick();
    n_vec++; if (enable !== 1'b1) begin n_bad++; $display("FAIL len_c1_enable got %b want 1", enable); end
    n_vec++; if (D !== 4'h5) begin n_bad++; $display("FAIL len_c1_D got %h want 5", D); end
    n_vec++; if (modo !== 2'd0) begin n_bad++; $display("FAIL len_c1_modo got %h want 0", modo); end
    tick();
    tick();
    n_vec++; if (enable !== 1'b1) begin n_bad++; $display("FAIL len_c3_enable got %b want 1", enable); end
    exp_q = q_in;
    tick();
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL len_c4_enable got %b want 0", enable); end
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL len_c4_done got %b want 1", done); end
    n_vec++; if (q_last !== exp_q) begin n_bad++; $display("FAIL len_q_last got %h want %h", q_last, exp_q); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL len_c5_done got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len_c5_busy got %b want 0", busy); end
    n_vec++; if (D !== 4'h5) begin n_bad++; $display("FAIL len_hold_D got %h want 5", D); end
  endtask

  task automatic test_len0();
    int w, cnt, base;
    base = n_done;
    cnt = 0;
    push(2'd1, 4'h9, 4'd0, 1'b0, w);
    repeat (20) begin
      tick();
      if (enable) cnt++;
    end
    n_vec++; if (cnt != 16) begin n_bad++; $display("FAIL len0_cycles got %0d want 16", cnt); end
    n_vec++; if (n_done - base != 1) begin n_bad++; $display("FAIL len0_done got %0d want 1", n_done - base); end
  endtask

  task automatic test_back_to_back();
    int w, base;
    logic [5:0] pat;
    logic [3:0] d_second;
    base = n_done;
    pat = '0;
    d_second = '0;
    push(2'd3, 4'hA, 4'd2, 1'b0, w);
    push(2'd2, 4'hC, 4'd2, 1'b0, w);
    for (int i = 0; i < 6; i++) begin
      pat = {pat[4:0], enable};
      if (i == 3) d_second = D;
      tick();
    end
    n_vec++; if (pat !== 6'b110110) begin n_bad++; $display("FAIL b2b_pattern got %b want 110110", pat); end
    n_vec++; if (d_second !== 4'hC) begin n_bad++; $display("FAIL b2b_D2 got %h want c", d_second); end
    n_vec++; if (n_done - base != 2) begin n_bad++; $display("FAIL b2b_done got %0d want 2", n_done - base); end
    n_vec++; if (modo !== 2'd2) begin n_bad++; $display("FAIL b2b_hold_modo got %h want 2", modo); end
    n_vec++; if (D !== 4'hC) begin n_bad++; $display("FAIL b2b_hold_D got %h want c", D); end
  endtask

  task automatic test_until_rco();
    int w, run;
    logic [3:0] exp_q;
    run = 0;
    push(2'd1, 4'h3, 4'd2, 1'b1, w);
    repeat (6) begin
      tick();
      if (enable) run++;
    end
    n_vec++; if (run != 6) begin n_bad++; $display("FAIL rco_run6 got %0d want 6", run); end
    tick();
    n_vec++; if (enable !== 1'b1) begin n_bad++; $display("FAIL rco_c7_enable got %b want 1", enable); end
    rco = 1'b1;
    exp_q = q_in;
    tick();
    rco = 1'b0;
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL rco_exit_enable got %b want 0", enable); end
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL rco_done got %b want 1", done); end
    n_vec++; if (q_last !== exp_q) begin n_bad++; $display("FAIL rco_q_last got %h want %h", q_last, exp_q); end
`ifdef CMD_SEQ_TIMEOUT_EN
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rco_err got %b want 0", err); end
`endif
    tick();
  endtask

  task automatic test_fifo_full();
    int w, base, dbase;
    logic [3:0] exp_d [6];
    exp_d = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
    base = starts.size();
    dbase = n_done;
    push(2'd0, 4'hF, 4'd0, 1'b0, w);
    tick();
    push(2'd0, 4'h1, 4'd1, 1'b0, w);
    push(2'd0, 4'h2, 4'd1, 1'b0, w);
    push(2'd0, 4'h3, 4'd1, 1'b0, w);
    push(2'd0, 4'h4, 4'd1, 1'b0, w);
    n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", cmd_ready); end
    push(2'd0, 4'h6, 4'd1, 1'b0, w);
    n_vec++; if (w != 14) begin n_bad++; $display("FAIL full_retry_wait got %0d want 14", w); end
    repeat (16) tick();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_drain_busy got %b want 0", busy); end
    n_vec++; if (n_done - dbase != 6) begin n_bad++; $display("FAIL full_done got %0d want 6", n_done - dbase); end
    n_vec++;
    if (starts.size() - base != 6) begin
      n_bad++; $display("FAIL full_starts got %0d want 6", starts.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (starts[base + i] !== exp_d[i]) begin
          n_bad++; $display("FAIL full_order[%0d] got %h want %h", i, starts[base + i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int w, dbase;
    logic [3:0] exp_q;
    push(2'd2, 4'h8, 4'd1, 1'b0, w);
    tick();
    exp_q = q_in;
    tick();
    tick();
    dbase = n_done;
    push(2'd1, 4'hE, 4'd0, 1'b0, w);
    tick();
    push(2'd1, 4'h1, 4'd1, 1'b0, w);
    push(2'd1, 4'h2, 4'd1, 1'b0, w);
    cmd_modo = 2'd3; cmd_d = 4'h9; cmd_len = 4'd1; cmd_until_rco = 1'b0;
    cmd_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL abort_enable got %b want 0", enable); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", cmd_ready); end
    n_vec++; if (q_last !== exp_q) begin n_bad++; $display("FAIL abort_q_last got %h want %h", q_last, exp_q); end
    repeat (4) tick();
    n_vec++; if (enable !== 1'b0) begin n_bad++; $display("FAIL abort_later_enable got %b want 0", enable); end
    n_vec++; if (n_done != dbase) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", n_done - dbase); end
  endtask

`ifdef CMD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int w, run, dbase;
    run = 0;
    dbase = n_done;
    push(2'd0, 4'h5, 4'd0, 1'b1, w);
    repeat (12) begin
      tick();
      if (enable) run++;
    end
    n_vec++; if (run != 8) begin n_bad++; $display("FAIL tmo_cycles got %0d want 8", run); end
    n_vec++; if (n_done - dbase != 1) begin n_bad++; $display("FAIL tmo_done got %0d want 1", n_done - dbase); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", err); end
    push(2'd0, 4'h1, 4'd1, 1'b0, w);
    repeat (4) tick();
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err_sticky got %b want 1", err); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_modo = '0;
    cmd_d = '0;
    cmd_len = '0;
    cmd_until_rco = 1'b0;
    abort = 1'b0;
    rco = 1'b0;
    q_in = 4'h0;
    test_reset();
    test_length();
    test_len0();
    test_back_to_back();
    test_until_rco();
    test_fifo_full();
    test_abort();
`ifdef CMD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
